// File: rtl/sifh_peak_search_if.sv
// -----------------------------------------------------------------------------
// sifh_peak_search_if
// Bundles the control handshake, the two histogram RAM ports and the result
// beat of the SiFH peak search stage.
//   start/busy/done                    : scan control
//   raddr/rEnable/readFlag/counts      : RAM port B (read)
//   waddr/wEnable/writeFlag/wdata      : RAM port A (clear writes)
//   peak_valid/pixel/bin/count         : one result beat per pixel
// modport master : the peak search block
// modport slave  : the environment (RAM + controller + result sink)
// -----------------------------------------------------------------------------
interface sifh_peak_search_if #(
    parameter int NB = 6,
    parameter int CW = 8,
    parameter int PW = 2,
    parameter int BW = 4
);
    logic          start;
    logic          busy;
    logic          done;
    logic [NB-1:0] raddr;
    logic          rEnable;
    logic          readFlag;
    logic [CW-1:0] counts;
    logic [NB-1:0] waddr;
    logic          wEnable;
    logic          writeFlag;
    logic [CW-1:0] wdata;
    logic          peak_valid;
    logic [PW-1:0] peak_pixel;
    logic [BW-1:0] peak_bin;
    logic [CW-1:0] peak_count;

    modport master (
        input  start, counts,
        output busy, done, raddr, rEnable, readFlag,
               waddr, wEnable, writeFlag, wdata,
               peak_valid, peak_pixel, peak_bin, peak_count
    );

    modport slave (
        output start, counts,
        input  busy, done, raddr, rEnable, readFlag,
               waddr, wEnable, writeFlag, wdata,
               peak_valid, peak_pixel, peak_bin, peak_count
    );
endinterface

// File: rtl/sifh_peak_search.sv
// -----------------------------------------------------------------------------
// sifh_peak_search
// On start, reads every bin of every pixel histogram from the shared RAM,
// reports the highest bin (lowest index on ties) per pixel as one result beat,
// and, when CLEAR_EN=1, zeroes each bin one cycle after it was read.
// Ports:
//   clk  : rising-edge clock
//   res  : asynchronous active-low reset
//   bus  : sifh_peak_search_if.master (control, RAM ports A/B, result beat)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sifh_peak_search #(
    parameter int BIN_NUM   = 16,
    parameter int PIXEL_NUM = 4,
    parameter int NB        = 6,
    parameter int CW        = 8,
    parameter int PW        = 2,
    parameter int BW        = 4,
    parameter bit CLEAR_EN  = 1'b1
) (
    input logic                  clk,
    input logic                  res,
    sifh_peak_search_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_REPORT = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    // Linear RAM address of one bin of one pixel histogram.
    function automatic logic [NB-1:0] addr_of(input logic [PW-1:0] pix, input logic [BW-1:0] bin);
        addr_of = NB'(pix) * NB'(BIN_NUM) + NB'(bin);
    endfunction

    state_t        state_r, state_s;
    logic [PW-1:0] pix_r, pix_s;
    logic [BW-1:0] bin_r, bin_s;          // bin currently on raddr
    logic [CW-1:0] max_r, max_s;
    logic [BW-1:0] maxbin_r, maxbin_s;
    logic          rd_d_r;                // counts carries valid data this cycle
    logic [BW-1:0] rd_bin_d_r;            // bin that counts belongs to
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [NB-1:0] raddr_r, raddr_s;
    logic          ren_r, ren_s;
    logic [NB-1:0] waddr_r, waddr_s;
    logic          wen_r, wen_s;
    logic          pv_r, pv_s;
    logic [PW-1:0] ppix_r, ppix_s;
    logic [BW-1:0] pbin_r, pbin_s;
    logic [CW-1:0] pcnt_r, pcnt_s;
    logic          upd_s;
    logic [CW-1:0] max_cmp_s;
    logic [BW-1:0] maxbin_cmp_s;

    // Running maximum including the word returned this cycle; strict > keeps lowest bin on ties.
    always_comb begin
        upd_s = rd_d_r && (bus.counts > max_r);
        if (upd_s) begin
            max_cmp_s    = bus.counts;
            maxbin_cmp_s = rd_bin_d_r;
        end else begin
            max_cmp_s    = max_r;
            maxbin_cmp_s = maxbin_r;
        end
    end

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_s  = state_r;
        pix_s    = pix_r;
        bin_s    = bin_r;
        max_s    = max_cmp_s;
        maxbin_s = maxbin_cmp_s;
        done_s   = 1'b0;
        raddr_s  = {NB{1'b0}};
        ren_s    = 1'b0;
        pv_s     = 1'b0;
        ppix_s   = {PW{1'b0}};
        pbin_s   = {BW{1'b0}};
        pcnt_s   = {CW{1'b0}};

        // The clear of an address always trails its read by exactly one cycle.
        if (CLEAR_EN && ren_r) begin
            waddr_s = raddr_r;
            wen_s   = 1'b1;
        end else begin
            waddr_s = {NB{1'b0}};
            wen_s   = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s  = ST_SCAN;
                    pix_s    = {PW{1'b0}};
                    bin_s    = {BW{1'b0}};
                    max_s    = {CW{1'b0}};
                    maxbin_s = {BW{1'b0}};
                    raddr_s  = addr_of({PW{1'b0}}, {BW{1'b0}});
                    ren_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bin_r == BW'(BIN_NUM - 1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    bin_s   = bin_r + 4'(1);
                    raddr_s = addr_of(pix_r, bin_r + 4'(1));
                    ren_s   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last word of the pixel is folded in here and reported straight away.
                state_s = ST_REPORT;
                pv_s    = 1'b1;
                ppix_s  = pix_r;
                pbin_s  = maxbin_cmp_s;
                pcnt_s  = max_cmp_s;
            end
            ST_REPORT: begin
                if (pix_r == PW'(PIXEL_NUM - 1)) begin
                    state_s = ST_FIN;
                    done_s  = 1'b1;
                end else begin
                    state_s  = ST_SCAN;
                    pix_s    = pix_r + 2'(1);
                    bin_s    = {BW{1'b0}};
                    max_s    = {CW{1'b0}};
                    maxbin_s = {BW{1'b0}};
                    raddr_s  = addr_of(pix_r + 2'(1), {BW{1'b0}});
                    ren_s    = 1'b1;
                end
            end
            ST_FIN: begin
                // start is deliberately not looked at here.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and registered output update; reset aborts any scan at once.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r    <= ST_IDLE;
            pix_r      <= {PW{1'b0}};
            bin_r      <= {BW{1'b0}};
            max_r      <= {CW{1'b0}};
            maxbin_r   <= {BW{1'b0}};
            rd_d_r     <= 1'b0;
            rd_bin_d_r <= {BW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            raddr_r    <= {NB{1'b0}};
            ren_r      <= 1'b0;
            waddr_r    <= {NB{1'b0}};
            wen_r      <= 1'b0;
            pv_r       <= 1'b0;
            ppix_r     <= {PW{1'b0}};
            pbin_r     <= {BW{1'b0}};
            pcnt_r     <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            pix_r      <= pix_s;
            bin_r      <= bin_s;
            max_r      <= max_s;
            maxbin_r   <= maxbin_s;
            rd_d_r     <= ren_r;
            rd_bin_d_r <= bin_r;
            busy_r     <= busy_s;
            done_r     <= done_s;
            raddr_r    <= raddr_s;
            ren_r      <= ren_s;
            waddr_r    <= waddr_s;
            wen_r      <= wen_s;
            pv_r       <= pv_s;
            ppix_r     <= ppix_s;
            pbin_r     <= pbin_s;
            pcnt_r     <= pcnt_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.raddr      = raddr_r;
    assign bus.rEnable    = ren_r;
    assign bus.readFlag   = ren_r;
    assign bus.waddr      = waddr_r;
    assign bus.wEnable    = wen_r;
    assign bus.writeFlag  = wen_r;
    assign bus.wdata      = {CW{1'b0}};
    assign bus.peak_valid = pv_r;
    assign bus.peak_pixel = ppix_r;
    assign bus.peak_bin   = pbin_r;
    assign bus.peak_count = pcnt_r;

endmodule

// File: tb/tb_sifh_peak_search.sv
// -----------------------------------------------------------------------------
// tb_sifh_peak_search
// Scoreboard bench: each scan pushes its expected result beats into a queue; a
// separate monitor pops and compares on every peak_valid, and also checks done
// latency, first-read latency and the read-then-clear pairing.
// -----------------------------------------------------------------------------
module tb_sifh_peak_search;

    typedef struct packed {
        logic [1:0] pix;
        logic [3:0] bin;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic res;
    logic load_req;
    logic [7:0] mem [64];
    logic [7:0] img [64];
    logic [7:0] counts_r;
    int   cyc;
    int   start_cyc;
    int   checks;
    int   failures;
    int   done_cnt;
    exp_t exp_q [$];

    sifh_peak_search_if #(.NB(6), .CW(8), .PW(2), .BW(4)) bus ();

    sifh_peak_search #(
        .BIN_NUM(16), .PIXEL_NUM(4), .NB(6), .CW(8), .PW(2), .BW(4), .CLEAR_EN(1'b1)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Histogram RAM model: one-cycle read latency on port B, writes on port A.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
        end else begin
            if (bus.rEnable && bus.readFlag) counts_r <= mem[bus.raddr];
            if (bus.wEnable && bus.writeFlag) mem[bus.waddr] <= bus.wdata;
        end
    end
    assign bus.counts = counts_r;

    function automatic exp_t mk(input int p, input int b, input int c);
        exp_t t;
        t.pix = 2'(p);
        t.bin = 4'(b);
        t.cnt = 8'(c);
        return t;
    endfunction

    // Reference peak: first bin holding the largest count.
    function automatic exp_t ref_peak(input int p);
        int best;
        int bb;
        best = 0;
        bb   = 0;
        for (int b = 0; b < 16; b++) begin
            if (int'(img[p*16 + b]) > best) begin
                best = int'(img[p*16 + b]);
                bb   = b;
            end
        end
        return mk(p, bb, best);
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 8'd0;
    endtask

    task automatic pattern_img();
        for (int i = 0; i < 64; i++) img[i] = 8'((i * 37 + 11) % 256);
    endtask

    task automatic load_mem();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (bus.busy || bus.done || bus.rEnable || bus.readFlag || bus.wEnable || bus.writeFlag ||
            bus.peak_valid || bus.raddr != 6'd0 || bus.waddr != 6'd0 || bus.wdata != 8'd0 ||
            bus.peak_pixel != 2'd0 || bus.peak_bin != 4'd0 || bus.peak_count != 8'd0) begin
            failures++;
            $display("FAIL %s: outputs busy=%0b done=%0b ren=%0b wen=%0b pv=%0b raddr=%0d peak=%0d/%0d/%0d, want all 0",
                     tag, bus.busy, bus.done, bus.rEnable, bus.wEnable, bus.peak_valid, bus.raddr,
                     bus.peak_pixel, bus.peak_bin, bus.peak_count);
        end
    endtask

    // One full scan; a second start pulse is issued at cycle extra_at (ignored by design).
    task automatic run_scan(input int extra_at, input string tag);
        int d0;
        bit got;
        d0  = done_cnt;
        got = 1'b0;
        @(negedge clk); bus.start = 1'b1; start_cyc = cyc;
        for (int k = 1; k < 200 && !got; k++) begin
            @(negedge clk);
            bus.start = (k == extra_at);
            if (done_cnt != d0) got = 1'b1;
        end
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!got) begin failures++; $display("FAIL %s_timeout: no done within 200 cycles", tag); end
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt - d0);
        end
        checks++;
        if (bus.busy) begin failures++; $display("FAIL %s_idle: busy=1 want 0", tag); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL %s_results: %0d expected beats missing, want 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Monitor: scoreboard pop/compare plus latency and clear-pairing checks.
    initial begin : monitor
        bit prev_busy;
        bit prev_ren;
        logic [5:0] prev_raddr;
        exp_t e;
        exp_t got_e;
        prev_busy  = 1'b0;
        prev_ren   = 1'b0;
        prev_raddr = 6'd0;
        forever begin
            @(negedge clk);
            if (res) begin
                if (bus.peak_valid) begin
                    checks++;
                    got_e = mk(int'(bus.peak_pixel), int'(bus.peak_bin), int'(bus.peak_count));
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL result_unexpected: got pix=%0d bin=%0d cnt=%0d want none",
                                 got_e.pix, got_e.bin, got_e.cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (got_e != e) begin
                            failures++;
                            $display("FAIL result: got pix=%0d bin=%0d cnt=%0d want pix=%0d bin=%0d cnt=%0d",
                                     got_e.pix, got_e.bin, got_e.cnt, e.pix, e.bin, e.cnt);
                        end
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    checks++;
                    if (cyc - start_cyc != 73) begin
                        failures++; $display("FAIL done_latency: got %0d want 73", cyc - start_cyc);
                    end
                end
                if (bus.busy && !prev_busy) begin
                    checks++;
                    if (cyc - start_cyc != 1 || !bus.rEnable || !bus.readFlag || bus.raddr != 6'd0) begin
                        failures++;
                        $display("FAIL first_read: cycle=%0d ren=%0b raddr=%0d want cycle 1 ren 1 raddr 0",
                                 cyc - start_cyc, bus.rEnable, bus.raddr);
                    end
                end
                if (prev_ren) begin
                    checks++;
                    if (!bus.wEnable || !bus.writeFlag || bus.waddr != prev_raddr || bus.wdata != 8'd0) begin
                        failures++;
                        $display("FAIL clear_write: wen=%0b wflag=%0b waddr=%0d wdata=%0d want 1 1 %0d 0",
                                 bus.wEnable, bus.writeFlag, bus.waddr, bus.wdata, prev_raddr);
                    end
                end else if (bus.wEnable) begin
                    checks++;
                    failures++;
                    $display("FAIL clear_spurious: wen=1 waddr=%0d want no write", bus.waddr);
                end
            end
            prev_busy  = bus.busy && res;
            prev_ren   = bus.rEnable && res;
            prev_raddr = bus.raddr;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d0;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        start_cyc = 0;
        res       = 1'b0;
        load_req  = 1'b0;
        bus.start = 1'b0;
        clear_img();

        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        res = 1'b1;
        @(negedge clk);

        // Single peak in pixel 0; start during FIN must be ignored.
        clear_img();
        img[5] = 8'd9;
        load_mem();
        exp_q.push_back(mk(0, 5, 9));
        exp_q.push_back(mk(1, 0, 0));
        exp_q.push_back(mk(2, 0, 0));
        exp_q.push_back(mk(3, 0, 0));
        run_scan(73, "single_peak");

        // Tie in pixel 2 keeps the lower bin; start mid-scan ignored.
        clear_img();
        img[2*16 + 3]  = 8'd200;
        img[2*16 + 7]  = 8'd199;
        img[2*16 + 11] = 8'd200;
        load_mem();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(1, 0, 0));
        exp_q.push_back(mk(2, 3, 200));
        exp_q.push_back(mk(3, 0, 0));
        run_scan(10, "tie_low_bin");

        // Full-scale in last bin; all-255 pixel and 255 tie in first/last bin.
        clear_img();
        img[1*16 + 0]  = 8'd254;
        img[1*16 + 15] = 8'd255;
        for (int b = 0; b < 16; b++) img[b] = 8'd255;
        img[3*16 + 0]  = 8'd255;
        img[3*16 + 15] = 8'd255;
        load_mem();
        exp_q.push_back(mk(0, 0, 255));
        exp_q.push_back(mk(1, 15, 255));
        exp_q.push_back(mk(2, 0, 0));
        exp_q.push_back(mk(3, 0, 255));
        run_scan(0, "full_scale");

        // Patterned histogram, then a rescan that must find everything cleared.
        pattern_img();
        load_mem();
        for (int p = 0; p < 4; p++) exp_q.push_back(ref_peak(p));
        run_scan(0, "pattern");
        for (int p = 0; p < 4; p++) exp_q.push_back(mk(p, 0, 0));
        run_scan(0, "after_clear");

        // Reset at cycle 30 aborts: only pixel 0 reported, no done.
        pattern_img();
        load_mem();
        exp_q.push_back(ref_peak(0));
        d0 = done_cnt;
        @(negedge clk); bus.start = 1'b1; start_cyc = cyc;
        @(negedge clk); bus.start = 1'b0;
        repeat (29) @(negedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        check_quiet("reset_mid_scan");
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (60) @(negedge clk);
        check_quiet("after_abort");
        checks++;
        if (done_cnt != d0) begin
            failures++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL abort_pixel0: %0d beats missing want 0", exp_q.size());
        end
        exp_q.delete();

        // Fresh scan after the abort starts again from pixel 0.
        load_mem();
        for (int p = 0; p < 4; p++) exp_q.push_back(ref_peak(p));
        run_scan(0, "rescan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
